// File: rtl/sha256_pkg.sv
// SHA-256 constants, round functions and FSM state type shared by the compression core.
package sha256_pkg;

  localparam logic [31:0] H0_INIT = 32'h6a09e667;
  localparam logic [31:0] H1_INIT = 32'hbb67ae85;
  localparam logic [31:0] H2_INIT = 32'h3c6ef372;
  localparam logic [31:0] H3_INIT = 32'ha54ff53a;
  localparam logic [31:0] H4_INIT = 32'h510e527f;
  localparam logic [31:0] H5_INIT = 32'h9b05688c;
  localparam logic [31:0] H6_INIT = 32'h1f83d9ab;
  localparam logic [31:0] H7_INIT = 32'h5be0cd19;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup: round index -> K[t].
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  assign k = K_TABLE[idx];

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression core: one round per cycle, schedule built in a 16-word window.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         done,
  output logic [6:0]   counter_iteration,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out,
  output logic [31:0]  e_out,
  output logic [31:0]  f_out,
  output logic [31:0]  g_out,
  output logic [31:0]  h_out
);

  state_e      state_q;
  logic        busy_q, done_q;
  logic [6:0]  cnt_q;
  logic [31:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0] w_q [16];

  logic [31:0] k_t, t1, t2, w_new;

  sha256_k_rom u_k_rom (
    .idx (cnt_q[5:0]),
    .k   (k_t)
  );

  always_comb begin
    t1    = h_q + big_sigma1(e_q) + ch(e_q, f_q, g_q) + k_t + w_q[0];
    t2    = big_sigma0(a_q) + maj(a_q, b_q, c_q);
    // Computed every round; the words produced after round 47 are simply never consumed.
    w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= H0_INIT;
      b_q     <= H1_INIT;
      c_q     <= H2_INIT;
      d_q     <= H3_INIT;
      e_q     <= H4_INIT;
      f_q     <= H5_INIT;
      g_q     <= H6_INIT;
      h_q     <= H7_INIT;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            a_q     <= H0_INIT;
            b_q     <= H1_INIT;
            c_q     <= H2_INIT;
            d_q     <= H3_INIT;
            e_q     <= H4_INIT;
            f_q     <= H5_INIT;
            g_q     <= H6_INIT;
            h_q     <= H7_INIT;
            for (int i = 0; i < 16; i++) w_q[i] <= block_in[511 - 32 * i -: 32];
          end
        end
        RUN: begin
          h_q   <= g_q;
          g_q   <= f_q;
          f_q   <= e_q;
          e_q   <= d_q + t1;
          d_q   <= c_q;
          c_q   <= b_q;
          b_q   <= a_q;
          a_q   <= t1 + t2;
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
          w_q[15] <= w_new;
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'd63) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign counter_iteration = cnt_q;
  assign a_out             = a_q;
  assign b_out             = b_q;
  assign c_out             = c_q;
  assign d_out             = d_q;
  assign e_out             = e_q;
  assign f_out             = f_q;
  assign g_out             = g_q;
  assign h_out             = h_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress against a full-schedule SHA-256 reference model.
module tb_sha256_compress;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic         busy, done;
  logic [6:0]   counter_iteration;
  logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV_ST = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};

  logic [255:0] ref_st [65];
  logic [255:0] dut_st;
  assign dut_st = {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out};

  sha256_compress dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .block_in          (block_in),
    .busy              (busy),
    .done              (done),
    .counter_iteration (counter_iteration),
    .a_out             (a_out),
    .b_out             (b_out),
    .c_out             (c_out),
    .d_out             (d_out),
    .e_out             (e_out),
    .f_out             (f_out),
    .g_out             (g_out),
    .h_out             (h_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: expands all 64 schedule words up front, records a..h after every round.
  task automatic run_model(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int j = 0; j < 8; j++) v[j] = IV_ST[255 - 32 * j -: 32];
    ref_st[0] = IV_ST;
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
      ref_st[t+1] = {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [511:0] blk);
    block_in = blk;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32 * i +: 32] = $urandom;
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({busy, done, counter_iteration} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b done=%b cnt=%0d want 0 0 0", busy, done,
               counter_iteration);
    end
    n_tests++;
    if (dut_st !== IV_ST) begin
      n_fail++;
      $display("FAIL reset_iv: got %h want %h", dut_st, IV_ST);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({busy, counter_iteration} !== 8'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got busy=%b cnt=%0d want 0 0", busy, counter_iteration);
    end
  endtask

  task automatic test_abc_rounds();
    run_model(ABC_BLK);
    launch(ABC_BLK);
    n_tests++;
    if (!(busy === 1'b1 && counter_iteration === 7'd0 && dut_st === IV_ST)) begin
      n_fail++;
      $display("FAIL abc_accept: got busy=%b cnt=%0d st=%h want 1 0 %h", busy,
               counter_iteration, dut_st, IV_ST);
    end
    for (int r = 0; r < 64; r++) begin
      tick();
      n_tests++;
      if (dut_st !== ref_st[r+1] || counter_iteration !== 7'(r + 1)) begin
        n_fail++;
        $display("FAIL abc_round%0d: got cnt=%0d st=%h want cnt=%0d st=%h", r,
                 counter_iteration, dut_st, r + 1, ref_st[r+1]);
      end
      n_tests++;
      if (done !== (r == 63) || busy !== (r != 63)) begin
        n_fail++;
        $display("FAIL abc_flags%0d: got done=%b busy=%b want %b %b", r, done, busy,
                 r == 63, r != 63);
      end
      if (r == 0) begin
        n_tests++;
        if (a_out !== 32'h5d6aebcd || e_out !== 32'hfa2a4622) begin
          n_fail++;
          $display("FAIL abc_r0_ae: got %h %h want 5d6aebcd fa2a4622", a_out, e_out);
        end
      end
    end
    n_tests++;
    if (a_out + 32'h6a09e667 !== 32'hba7816bf || h_out + 32'h5be0cd19 !== 32'hf20015ad) begin
      n_fail++;
      $display("FAIL abc_digest: got %h %h want ba7816bf f20015ad", a_out + 32'h6a09e667,
               h_out + 32'h5be0cd19);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || counter_iteration !== 7'd64 || dut_st !== ref_st[64])
    begin
      n_fail++;
      $display("FAIL abc_after: got done=%b busy=%b cnt=%0d want 0 0 64", done, busy,
               counter_iteration);
    end
  endtask

  task automatic test_empty();
    run_model(EMPTY_BLK);
    launch(EMPTY_BLK);
    repeat (64) tick();
    n_tests++;
    if (done !== 1'b1 || counter_iteration !== 7'd64 || dut_st !== ref_st[64]) begin
      n_fail++;
      $display("FAIL empty_final: got done=%b cnt=%0d st=%h want 1 64 %h", done,
               counter_iteration, dut_st, ref_st[64]);
    end
    n_tests++;
    if (a_out + 32'h6a09e667 !== 32'he3b0c442 || h_out + 32'h5be0cd19 !== 32'h7852b855) begin
      n_fail++;
      $display("FAIL empty_digest: got %h %h want e3b0c442 7852b855", a_out + 32'h6a09e667,
               h_out + 32'h5be0cd19);
    end
  endtask

  task automatic test_random();
    logic [511:0] blk;
    for (int n = 0; n < 4; n++) begin
      blk = rand_block();
      run_model(blk);
      launch(blk);
      repeat (64) tick();
      n_tests++;
      if (done !== 1'b1 || dut_st !== ref_st[64]) begin
        n_fail++;
        $display("FAIL random%0d: got done=%b st=%h want 1 %h", n, done, dut_st, ref_st[64]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen_done = 0;
    launch(ABC_BLK);
    repeat (30) tick();
    n_tests++;
    if (counter_iteration !== 7'd30) begin
      n_fail++;
      $display("FAIL mid_cnt: got %0d want 30", counter_iteration);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || counter_iteration !== 7'd0 || dut_st !== IV_ST) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b done=%b cnt=%0d st=%h want 0 0 0 %h", busy, done,
               counter_iteration, dut_st, IV_ST);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
    end
    n_tests++;
    if (seen_done || counter_iteration !== 7'd0) begin
      n_fail++;
      $display("FAIL mid_quiet: got activity=%b cnt=%0d want 0 0", seen_done,
               counter_iteration);
    end
    run_model(ABC_BLK);
    launch(ABC_BLK);
    repeat (64) tick();
    n_tests++;
    if (done !== 1'b1 || dut_st !== ref_st[64]) begin
      n_fail++;
      $display("FAIL mid_rerun: got done=%b st=%h want 1 %h", done, dut_st, ref_st[64]);
    end
  endtask

  task automatic test_start_during_run();
    logic [511:0] blk_x, blk_y;
    blk_x = rand_block();
    blk_y = rand_block();
    run_model(blk_x);
    launch(blk_x);
    repeat (10) tick();
    block_in = blk_y;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || counter_iteration !== 7'd11 || dut_st !== ref_st[11]) begin
      n_fail++;
      $display("FAIL ignore_start: got busy=%b cnt=%0d want 1 11", busy, counter_iteration);
    end
    repeat (53) tick();
    n_tests++;
    if (done !== 1'b1 || dut_st !== ref_st[64]) begin
      n_fail++;
      $display("FAIL ignore_final: got done=%b st=%h want 1 %h", done, dut_st, ref_st[64]);
    end
  endtask

  task automatic test_restart_from_done();
    logic [255:0] held;
    held = ref_st[64];
    repeat (3) tick();
    n_tests++;
    if (dut_st !== held || counter_iteration !== 7'd64 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: got cnt=%0d done=%b st=%h want 64 0 %h", counter_iteration,
               done, dut_st, held);
    end
    run_model(EMPTY_BLK);
    launch(EMPTY_BLK);
    n_tests++;
    if (busy !== 1'b1 || counter_iteration !== 7'd0) begin
      n_fail++;
      $display("FAIL restart_accept: got busy=%b cnt=%0d want 1 0", busy, counter_iteration);
    end
    repeat (64) tick();
    n_tests++;
    if (done !== 1'b1 || a_out + 32'h6a09e667 !== 32'he3b0c442 || dut_st !== ref_st[64]) begin
      n_fail++;
      $display("FAIL restart_digest: got done=%b a+iv=%h want 1 e3b0c442", done,
               a_out + 32'h6a09e667);
    end
    rst = 1'b0;
    block_in = ABC_BLK;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (busy !== 1'b0 || counter_iteration !== 7'd0 || done !== 1'b0 || dut_st !== IV_ST) begin
        n_fail++;
        $display("FAIL rst_vs_start%0d: got busy=%b cnt=%0d done=%b want 0 0 0", i, busy,
                 counter_iteration, done);
      end
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_abc_rounds();
    test_empty();
    test_random();
    test_reset_mid_run();
    test_start_during_run();
    test_restart_from_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

- Upstream stage of the digest accumulator: runs the 64 SHA-256 compression rounds on one 512-bit padded message block.
- Generates the message schedule on the fly.
- Exposes working variables a..h and a round counter. The accumulator adds them to H0..H7 when the counter reaches 64.
- Single-block operation: the working variables always start from the standard IV.

## Interface

Parameters:
- none; all constants are fixed by FIPS 180-4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin compressing block_in; honoured only in IDLE or DONE.
- block_in  in  512  padded block, big-endian: bits [511:480] = W0, bits [31:0] = W15; sampled only on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on the edge that completes round 63.
- counter_iteration  out  7  rounds completed, 0..64; holds 64 in DONE.
- a_out … h_out  out  32 each  registered working variables a..h.

## Operation

State machine: IDLE, RUN, DONE.
- IDLE -> RUN on start. The accepting edge:
  - loads a..h with the IV (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19);
  - loads the 16-word window with W0..W15;
  - sets counter_iteration = 0.
- RUN: each cycle executes round t = counter_iteration, then increments the counter.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - next: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2
- All additions are modulo 2^32; carries are discarded.
- Message schedule: a 16-word shift window w[0..15]; W[t] = w[0] every round.
  - new = σ1(w[14]) + w[9] + σ0(w[1]) + w[0]
  - shift left by one word; new enters w[15].
  - The new word is computed every round, including rounds ≥48 where it is unused.
- Function definitions:
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10
- RUN -> DONE on the round-63 edge (counter becomes 64). done pulses high on that edge.
- DONE: a..h and counter_iteration are held stable indefinitely.
  - start in DONE restarts exactly as from IDLE.
  - The downstream accumulator captures once per reset, so multi-block messages require a reset between blocks.
- start during RUN is ignored; the current computation is unaffected.

## Timing

- Reset values (rst low at a posedge):
  - state IDLE, busy 0, done 0, counter_iteration 0;
  - a..h = IV; window cleared to 0.
- Reset mid-RUN aborts immediately to these values. No partial result is ever reported with counter 64.
- Latency, with start sampled at edge E0:
  - RUN is entered with counter 0 after E0;
  - counter = 64, done = 1 and final a..h are visible after edge E64, i.e. 65 edges including E0;
  - busy is high from after E0 until after E64.
- done is high for exactly one cycle. counter_iteration stays 64 after done falls.
- Simultaneous rst low and start: reset wins.
- counter_iteration never exceeds 64 and never wraps.
- Outputs are directly registered; there is no combinational path from start or block_in to any output.

## Structure

- Package sha256_pkg:
  - IV constants H0_INIT..H7_INIT;
  - the 64-entry K constant array;
  - functions big_sigma0/1, small_sigma0/1, ch, maj;
  - state enum {IDLE, RUN, DONE}.
- One sub-module: sha256_k_rom, a combinational 6-bit index -> 32-bit K[t] lookup from the package array.
- The top module holds the FSM, counter, working registers and schedule window.

## Test plan

- "abc" block (61626380 00…00 00000018):
  - after 65 edges, done pulses and counter = 64;
  - a_out+6a09e667 = ba7816bf; h_out+5be0cd19 = f20015ad.
- Empty-message block (80000000, 0…0):
  - a_out+IV0 = e3b0c442; h_out+IV7 = 7852b855.
- Per-round check on "abc" against a reference model:
  - after round 0, a_out = 5d6aebcd, e_out = fa2a4622.
- Reset asserted at counter 30:
  - next cycle: IDLE, counter 0, a..h = IV, busy 0, done never pulses;
  - a new start then gives the correct "abc" result.
- start pulsed at counter 10 with a different block:
  - ignored; final result equals the original block's.
- start in DONE with the empty-message block:
  - restarts; correct e3b0c442 result after 65 edges;
  - rst held low with start high: stays IDLE.
